// File: rtl/alu_arbiter_pkg.sv
// Shared CPU definitions: ALU opcode encodings and the operand/result payloads
// carried between the issue stage and the ALU.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [OP_W-1:0] aluop_t;

  localparam aluop_t ALUOP_ADDSUB = 3'd0;
  localparam aluop_t ALUOP_SHL    = 3'd1;
  localparam aluop_t ALUOP_SLT    = 3'd2;
  localparam aluop_t ALUOP_PASSB  = 3'd3;
  localparam aluop_t ALUOP_XOR    = 3'd4;
  localparam aluop_t ALUOP_SHR    = 3'd5;
  localparam aluop_t ALUOP_OR     = 3'd6;
  localparam aluop_t ALUOP_AND    = 3'd7;

  typedef struct packed {
    aluop_t              aluop;
    logic                aluctr;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } alu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]   result;
    logic                less;
    logic                zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. aluctr selects subtract for add/sub, unsigned
// compare for Less, and arithmetic shift for shr.
module alu
  import alu_arbiter_pkg::*;
(
  input  alu_req_t req,
  output alu_rsp_t rsp_c
);

  logic [SHAMT_W-1:0] shamt_c;
  logic [DATA_W-1:0]  result_c;
  logic               less_c;

  always_comb begin
    shamt_c  = req.b[SHAMT_W-1:0];
    less_c   = req.aluctr ? (req.a < req.b) : ($signed(req.a) < $signed(req.b));
    result_c = '0;
    case (req.aluop)
      ALUOP_ADDSUB: result_c = req.aluctr ? (req.a - req.b) : (req.a + req.b);
      ALUOP_SHL:    result_c = req.a << shamt_c;
      ALUOP_SLT:    result_c = DATA_W'(less_c);
      ALUOP_PASSB:  result_c = req.b;
      ALUOP_XOR:    result_c = req.a ^ req.b;
      ALUOP_SHR:    result_c = req.aluctr ? DATA_W'($signed(req.a) >>> shamt_c)
                                          : (req.a >> shamt_c);
      ALUOP_OR:     result_c = req.a | req.b;
      ALUOP_AND:    result_c = req.a & req.b;
      default:      result_c = '0;
    endcase
    rsp_c.result = result_c;
    rsp_c.less   = less_c;
    rsp_c.zero   = (result_c == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: round-robin grant into an issue
// register S1, then per-requester response registers R0/R1.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TAGW = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_aluop,
  input  logic              req0_aluctr,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [TAGW-1:0]   req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_aluop,
  input  logic              req1_aluctr,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [TAGW-1:0]   req1_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_result,
  output logic              rsp0_less,
  output logic              rsp0_zero,
  output logic [TAGW-1:0]   rsp0_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_result,
  output logic              rsp1_less,
  output logic              rsp1_zero,
  output logic [TAGW-1:0]   rsp1_tag,
  output logic [CNTW-1:0]   ops_issued
);

  alu_req_t [1:0]            req_c;
  logic [1:0]                req_valid_c;
  logic [1:0][TAGW-1:0]      req_tag_c;
  logic [1:0]                pop_c;
  logic [1:0]                ready_c;
  logic                      s1_adv_c;
  logic                      s1_free_c;
  logic                      grant_c;
  logic                      accept_c;
  alu_rsp_t                  alu_rsp_c;

  logic                      s1_valid_q, s1_valid_d;
  alu_req_t                  s1_op_q,    s1_op_d;
  logic [TAGW-1:0]           s1_tag_q,   s1_tag_d;
  logic                      s1_src_q,   s1_src_d;
  logic [1:0]                r_valid_q,  r_valid_d;
  alu_rsp_t [1:0]            r_rsp_q,    r_rsp_d;
  logic [1:0][TAGW-1:0]      r_tag_q,    r_tag_d;
  logic                      prio_q,     prio_d;
  logic                      lock_q,     lock_d;
  logic                      lock_id_q,  lock_id_d;
  logic [CNTW-1:0]           ops_q,      ops_d;

  alu u_alu (
    .req   (s1_op_q),
    .rsp_c (alu_rsp_c)
  );

  // Arbitration, pipeline advance and next-state
  always_comb begin
    req_c[0]    = '{aluop: req0_aluop, aluctr: req0_aluctr, a: req0_a, b: req0_b};
    req_c[1]    = '{aluop: req1_aluop, aluctr: req1_aluctr, a: req1_a, b: req1_b};
    req_tag_c   = {req1_tag, req0_tag};
    req_valid_c = {req1_valid, req0_valid};

    pop_c     = r_valid_q & {rsp1_ready, rsp0_ready};
    s1_adv_c  = s1_valid_q & (~r_valid_q[s1_src_q] | pop_c[s1_src_q]);
    s1_free_c = ~s1_valid_q | s1_adv_c;

    // A stalled grant stays put until its requester is taken
    if (lock_q)             grant_c = lock_id_q;
    else if (&req_valid_c)  grant_c = prio_q;
    else                    grant_c = req_valid_c[1];

    ready_c          = 2'b00;
    ready_c[grant_c] = s1_free_c & rst_n;
    accept_c         = req_valid_c[grant_c] & ready_c[grant_c];

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    r_valid_d  = r_valid_q;
    r_rsp_d    = r_rsp_q;
    r_tag_d    = r_tag_q;
    prio_d     = prio_q;
    lock_d     = req_valid_c[grant_c] & ~s1_free_c;
    lock_id_d  = grant_c;
    ops_d      = ops_q + CNTW'(accept_c);

    if (s1_adv_c) s1_valid_d = 1'b0;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_op_d    = req_c[grant_c];
      s1_tag_d   = req_tag_c[grant_c];
      s1_src_d   = grant_c;
      prio_d     = ~grant_c;
    end

    for (int i = 0; i < 2; i++) begin
      if (pop_c[i]) r_valid_d[i] = 1'b0;
      if (s1_adv_c && (s1_src_q == 1'(i))) begin
        r_valid_d[i] = 1'b1;
        r_rsp_d[i]   = alu_rsp_c;
        r_tag_d[i]   = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_src_q   <= 1'b0;
      r_valid_q  <= '0;
      r_rsp_q    <= '0;
      r_tag_q    <= '0;
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
      ops_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_src_q   <= s1_src_d;
      r_valid_q  <= r_valid_d;
      r_rsp_q    <= r_rsp_d;
      r_tag_q    <= r_tag_d;
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      ops_q      <= ops_d;
    end
  end

  assign req0_ready  = ready_c[0];
  assign req1_ready  = ready_c[1];
  assign rsp0_valid  = r_valid_q[0];
  assign rsp0_result = r_rsp_q[0].result;
  assign rsp0_less   = r_rsp_q[0].less;
  assign rsp0_zero   = r_rsp_q[0].zero;
  assign rsp0_tag    = r_tag_q[0];
  assign rsp1_valid  = r_valid_q[1];
  assign rsp1_result = r_rsp_q[1].result;
  assign rsp1_less   = r_rsp_q[1].less;
  assign rsp1_zero   = r_rsp_q[1].zero;
  assign rsp1_tag    = r_tag_q[1];
  assign ops_issued  = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester stimulus queues feed the
// request ports, expected responses are queued on acceptance and compared on pop.
module tb_alu_arbiter;

  localparam int unsigned TAGW = 4;
  localparam int unsigned CNTW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req0_valid = 0, req1_valid = 0;
  logic            req0_ready, req1_ready;
  logic [2:0]      req0_aluop = 0, req1_aluop = 0;
  logic            req0_aluctr = 0, req1_aluctr = 0;
  logic [31:0]     req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [TAGW-1:0] req0_tag = 0, req1_tag = 0;
  logic            rsp0_valid, rsp1_valid;
  logic            rsp0_ready = 1, rsp1_ready = 1;
  logic [31:0]     rsp0_result, rsp1_result;
  logic            rsp0_less, rsp1_less, rsp0_zero, rsp1_zero;
  logic [TAGW-1:0] rsp0_tag, rsp1_tag;
  logic [CNTW-1:0] ops_issued;

  alu_arbiter #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_aluctr(req0_aluctr), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_aluctr(req1_aluctr), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_less(rsp0_less), .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_less(rsp1_less), .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
    .ops_issued(ops_issued)
  );

  typedef struct {
    logic [2:0]      op;
    logic            ctr;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TAGW-1:0] tag;
  } stim_t;

  stim_t       sq0[$], sq1[$];
  logic [37:0] eq0[$], eq1[$];
  bit          acc0 = 0, acc1 = 0;
  int          n_cmp = 0, n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [2:0] op, input logic ctr, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAGW-1:0] tag);
    stim_t s;
    s.op = op; s.ctr = ctr; s.a = a; s.b = b; s.tag = tag;
    return s;
  endfunction

  // Reference ALU: returns {result, less, zero}
  function automatic logic [33:0] alu_model(input logic [2:0] op, input logic ctr,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] ext;
    logic        less;
    int          sh;
    sh = int'(b[4:0]);
    if (ctr) less = (a < b);
    else     less = (a[31] != b[31]) ? a[31] : (a < b);
    ext = {{32{ctr & a[31]}}, a} >> sh;
    case (op)
      3'd0: r = ctr ? a + ~b + 32'd1 : a + b;
      3'd1: r = a << sh;
      3'd2: r = {31'd0, less};
      3'd3: r = b;
      3'd4: r = a ^ b;
      3'd5: r = ext[31:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {r, less, (r == 32'd0)};
  endfunction

  // Monitor: record handshakes and compare popped responses
  always @(negedge clk) begin
    acc0 = rst_n && req0_valid && req0_ready;
    acc1 = rst_n && req1_valid && req1_ready;
    if (rst_n) begin
      if (acc0) eq0.push_back({alu_model(req0_aluop, req0_aluctr, req0_a, req0_b), req0_tag});
      if (acc1) eq1.push_back({alu_model(req1_aluop, req1_aluctr, req1_a, req1_b), req1_tag});
      if (rsp0_valid && rsp0_ready) begin
        if (eq0.size() == 0) check("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else check("rsp0_data", 64'({rsp0_result, rsp0_less, rsp0_zero, rsp0_tag}),
                   64'(eq0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (eq1.size() == 0) check("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else check("rsp1_data", 64'({rsp1_result, rsp1_less, rsp1_zero, rsp1_tag}),
                   64'(eq1.pop_front()));
      end
    end
  end

  // Requester 0 driver; idle fields carry junk
  always @(posedge clk) begin
    #1;
    if (acc0 && sq0.size() > 0) sq0.delete(0);
    if (sq0.size() > 0) begin
      req0_valid = 1; req0_aluop = sq0[0].op; req0_aluctr = sq0[0].ctr;
      req0_a = sq0[0].a; req0_b = sq0[0].b; req0_tag = sq0[0].tag;
    end else begin
      req0_valid = 0; req0_aluop = 3'($urandom); req0_aluctr = 1'($urandom);
      req0_a = $urandom; req0_b = $urandom; req0_tag = TAGW'($urandom);
    end
  end

  always @(posedge clk) begin
    #1;
    if (acc1 && sq1.size() > 0) sq1.delete(0);
    if (sq1.size() > 0) begin
      req1_valid = 1; req1_aluop = sq1[0].op; req1_aluctr = sq1[0].ctr;
      req1_a = sq1[0].a; req1_b = sq1[0].b; req1_tag = sq1[0].tag;
    end else begin
      req1_valid = 0; req1_aluop = 3'($urandom); req1_aluctr = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_tag = TAGW'($urandom);
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sq0.size() + sq1.size() + eq0.size() + eq1.size()), 64'd0);
  endtask

  initial begin
    int wc;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_ops", 64'(ops_issued), 64'd0);
    check("rst_rsp0_result", 64'(rsp0_result), 64'd0);
    @(posedge clk); #3 rst_n = 1;

    // Single add, latency of two edges from acceptance
    @(negedge clk);
    sq0.push_back(mk(3'd0, 1'b0, 32'd5, 32'd7, 4'd3));
    @(negedge clk); check("t1_ready", 64'(req0_ready), 64'd1);
    @(negedge clk); check("t1_early_valid", 64'(rsp0_valid), 64'd0);
    check("t1_ops", 64'(ops_issued), 64'd1);
    @(negedge clk); check("t1_valid", 64'(rsp0_valid), 64'd1);
    check("t1_result", 64'(rsp0_result), 64'd12);
    check("t1_tag", 64'(rsp0_tag), 64'd3);
    check("t1_zero", 64'(rsp0_zero), 64'd0);
    wait_drain(20);

    // Round-robin with both requesters valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sq0.push_back(mk(3'd6, 1'b0, 32'hF0, 32'h0F, TAGW'(i)));
      sq1.push_back(mk(3'd7, 1'b0, 32'hFF, 32'h0F, TAGW'(i + 4)));
    end
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("rr_grant", 64'({req1_ready, req0_ready}), (g % 2 == 1) ? 64'd2 : 64'd1);
    end
    wait_drain(20);

    // R1 held full: S1 stalls on req1, req0 served beforehand, then all drain
    do_reset();
    rsp1_ready = 0;
    @(negedge clk);
    sq1.push_back(mk(3'd0, 1'b1, 32'd100, 32'd1, 4'd1));
    repeat (4) @(negedge clk);
    check("stall_r1_full", 64'(rsp1_valid), 64'd1);
    sq0.push_back(mk(3'd4, 1'b0, 32'hAA, 32'h55, 4'd2));
    sq1.push_back(mk(3'd1, 1'b0, 32'd1, 32'd4, 4'd2));
    sq1.push_back(mk(3'd5, 1'b1, 32'h8000_0000, 32'd4, 4'd3));
    repeat (6) @(negedge clk);
    check("stall_req1_ready", 64'(req1_ready), 64'd0);
    check("stall_hold_result", 64'(rsp1_result), 64'd99);
    check("stall_req0_served", 64'(eq0.size()), 64'd0);
    check("stall_ops", 64'(ops_issued), 64'd3);
    @(posedge clk); #2 rsp1_ready = 1;
    wait_drain(30);
    check("stall_ops_done", 64'(ops_issued), 64'd4);

    // Back-to-back issue on requester 0
    @(negedge clk);
    for (int i = 0; i < 8; i++) sq0.push_back(mk(3'd0, 1'b0, 32'(i), 32'(3 * i), TAGW'(i)));
    wc = 0;
    @(negedge clk);
    while (!rsp0_valid && wc < 10) begin @(negedge clk); wc++; end
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", 64'(rsp0_valid), 64'd1);
      check("b2b_tag", 64'(rsp0_tag), 64'(i));
      @(negedge clk);
    end
    wait_drain(20);

    // Random operations with random response back-pressure
    for (int i = 0; i < 24; i++) begin
      sq0.push_back(mk(3'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, TAGW'(i)));
      sq1.push_back(mk(3'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, TAGW'(i)));
    end
    repeat (80) begin
      @(posedge clk); #2;
      rsp0_ready = ($urandom % 4) != 0;
      rsp1_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #2 rsp0_ready = 1; rsp1_ready = 1;
    wait_drain(200);
    check("mix_ops", 64'(ops_issued), 64'd60);

    // Reset while S1 and R0 hold operations
    rsp0_ready = 0;
    @(negedge clk);
    sq0.push_back(mk(3'd3, 1'b0, 32'd0, 32'h1234, 4'd9));
    sq0.push_back(mk(3'd3, 1'b0, 32'd0, 32'h5678, 4'd10));
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 0;
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    #1;
    check("arst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("arst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("arst_req0_ready", 64'(req0_ready), 64'd0);
    check("arst_ops", 64'(ops_issued), 64'd0);
    check("arst_rsp0_result", 64'(rsp0_result), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1; rsp0_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("arst_no_stale", 64'(rsp0_valid), 64'd0);
    end

    // Counter wrap after 2^CNTW accepted requests
    for (int i = 0; i < (1 << CNTW) - 1; i++)
      sq0.push_back(mk(3'd3, 1'b0, 32'd0, 32'(i), TAGW'(i)));
    wait_drain(70000);
    check("wrap_pre", 64'(ops_issued), 64'hFFFF);
    sq0.push_back(mk(3'd3, 1'b0, 32'd0, 32'd7, 4'd7));
    wait_drain(20);
    check("wrap_zero", 64'(ops_issued), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
